// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared definitions for the branch predictor and branch unit:
//                2-bit counter states, the saturating counter update,
//                default geometry, and the branch funct3 codes.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_pkg;

   // Default geometry
   localparam int DEF_INDEX_BITS = 6;
   localparam int DEF_XLEN       = 32;

   // 2-bit saturating counter states
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Conditional branch funct3 codes, shared by branch_logic and the decoder
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Saturating next state: move toward ST on taken, toward SNT otherwise
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (ctr == ST) ? ST : ctr + 2'd1;
      end else begin
         nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped BTB with per-entry 2-bit saturating counters.
//                Combinational lookup for the fetch PC, update from the
//                resolved branch in EX, mispredict flag and statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int XLEN       = DEF_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   output logic            mispredict,
   output logic [31:0]     branch_count,
   output logic [31:0]     mispred_count
);

   localparam int c_ENTRIES = 1 << INDEX_BITS;
   localparam int c_TAG_W   = XLEN - INDEX_BITS - 2;

   // Entry storage kept in flops so that reset clears everything in one cycle
   logic                  r_valid  [c_ENTRIES];
   logic [c_TAG_W-1:0]    r_tag    [c_ENTRIES];
   logic [XLEN-1:0]       r_target [c_ENTRIES];
   logic [1:0]            r_ctr    [c_ENTRIES];
   logic [31:0]           r_branch_count;
   logic [31:0]           r_mispred_count;

   logic [INDEX_BITS-1:0] w_if_idx;
   logic [c_TAG_W-1:0]    w_if_tag;
   logic                  w_if_hit;
   logic [INDEX_BITS-1:0] w_upd_idx;
   logic [c_TAG_W-1:0]    w_upd_tag;
   logic                  w_upd_hit;
   logic                  w_mispredict;
   logic                  w_unused;

   assign w_if_idx  = if_pc[INDEX_BITS+1:2];
   assign w_if_tag  = if_pc[XLEN-1:INDEX_BITS+2];
   assign w_upd_idx = upd_pc[INDEX_BITS+1:2];
   assign w_upd_tag = upd_pc[XLEN-1:INDEX_BITS+2];

   // Instruction alignment bits never take part in indexing or tagging
   assign w_unused = ^{if_pc[1:0], upd_pc[1:0]};

   // Lookup reads stored state only; an update in the same cycle is not bypassed
   always_comb begin
      w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
      pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
      pred_target = pred_taken ? r_target[w_if_idx] : '0;
   end

   // Hit detection for the resolving branch and direction mispredict flag
   always_comb begin
      w_upd_hit    = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
      w_mispredict = upd_valid && (upd_taken != upd_pred_taken);
   end

   assign mispredict    = w_mispredict;
   assign branch_count  = r_branch_count;
   assign mispred_count = r_mispred_count;

   // Entry training, allocation and statistics; reset overrides any update
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= WNT;
         end
         r_branch_count  <= '0;
         r_mispred_count <= '0;
      end else if (upd_valid) begin
         r_branch_count <= r_branch_count + 32'd1;
         if (w_mispredict) begin
            r_mispred_count <= r_mispred_count + 32'd1;
         end
         if (w_upd_hit) begin
            r_ctr[w_upd_idx] <= ctr_next(r_ctr[w_upd_idx], upd_taken);
            if (upd_taken) begin
               r_target[w_upd_idx] <= upd_target;
            end
         end else if (upd_taken) begin
            // Only a taken resolution may evict an aliasing entry
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
            r_ctr[w_upd_idx]    <= WT;
         end
      end
   end

endmodule : branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the RISC-V pipeline: a direct-mapped branch target buffer with per-entry 2-bit saturating counters. In IF it predicts direction and target for the fetch PC. In EX it consumes the resolved outcome from `branch_logic` (`taken`) and updates its state. It also flags direction mispredicts and keeps branch and mispredict statistics.

## Interface
Parameters:
- `INDEX_BITS`, 6: number of entries is 2^INDEX_BITS.
- `XLEN`, 32: PC and target width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `if_pc`  in  XLEN  fetch-stage PC to predict.
- `pred_taken`  out  1  predicted taken for `if_pc`.
- `pred_target`  out  XLEN  predicted target; 0 when `pred_taken`=0.
- `upd_valid`  in  1  EX stage holds a resolved conditional branch this cycle.
- `upd_pc`  in  XLEN  PC of the resolved branch.
- `upd_taken`  in  1  resolved outcome, driven from `branch_logic.taken`.
- `upd_target`  in  XLEN  computed branch target (PC + B-immediate).
- `upd_pred_taken`  in  1  prediction made in IF for this branch, carried down the pipeline.
- `mispredict`  out  1  `upd_valid & (upd_taken != upd_pred_taken)`, combinational.
- `branch_count`  out  32  number of resolved branches since reset.
- `mispred_count`  out  32  number of mispredicts since reset.

## Operation
- Index = `pc[INDEX_BITS+1:2]`. Tag = `pc[XLEN-1:INDEX_BITS+2]`.
- Each entry holds `valid`, `tag`, `target`, and `ctr[1:0]`.
- Counter encoding:
  - SNT = 00, strongly not taken
  - WNT = 01, weakly not taken
  - WT = 10, weakly taken
  - ST = 11, strongly taken
- Lookup (combinational from stored state):
  - hit = `valid & (tag == if_pc tag)`.
  - `pred_taken` = hit & `ctr[1]`.
  - `pred_target` = `target` when `pred_taken`, else 0.
- Update at the clock edge when `upd_valid`:
  - Hit, taken: `ctr` increments, saturating at ST; `target` ← `upd_target`.
  - Hit, not taken: `ctr` decrements, saturating at SNT; `target` unchanged.
  - Miss, taken: allocate or overwrite the entry with `valid`=1, new tag, `target`=`upd_target`, `ctr`=WT.
  - Miss, not taken: no state change.
- Counters:
  - `branch_count` increments on every `upd_valid`.
  - `mispred_count` increments when `mispredict`=1.
  - Both wrap modulo 2^32.
- `upd_valid`=0: no state change, and `mispredict`=0.
- The predictor reports direction mispredicts only. Target mismatch is impossible for a tag-matched direct conditional branch and is not checked.

## Timing
- Prediction latency is 0 cycles: outputs are a pure function of `if_pc` and registered state.
- Update is visible to lookup from the cycle after the `upd_valid` edge.
- Simultaneous lookup and update of the same index: lookup returns the pre-update value. There is no bypass.
- Reset:
  - On the edge with `rst`=1, all `valid` ← 0, all `ctr` ← WNT, all `target` and `tag` ← 0, and both statistics counters ← 0.
  - From the next cycle, `pred_taken`=0 and `pred_target`=0 for every PC.
  - `mispredict` stays combinational during reset.
  - `rst` wins over a concurrent `upd_valid`; that update is discarded and not counted.
- Reset asserted mid-stream clears all learned state in one cycle. Updates resume normally on the first cycle after `rst` deasserts.
- Aliasing: two PCs with equal index but different tag evict each other, but only on a taken resolution.

## Structure
- Shared package `bp_pkg`:
  - counter state constants SNT/WNT/WT/ST;
  - `ctr_next(ctr, taken)` saturating next-state function;
  - default `INDEX_BITS` and `XLEN`.
- Storage is flop arrays, not SRAM, so that a single-cycle reset is possible.
- No sub-module; the entry update logic is small enough to stay in the one module alongside the storage.
- The branch funct3 codes (BEQ=000 … BGEU=111) already used by `branch_logic` move into the same package. `branch_logic` and the decoder then share them.

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0, both counters 0.
- Update 0x100 taken with target 0x140 (`upd_pred_taken`=0) → `mispredict`=1 that cycle. Next cycle, lookup 0x100 gives `pred_taken`=1, `pred_target`=0x140, `mispred_count`=1.
- Counter saturation on the entry for 0x100:
  - 3 more taken updates → `ctr`=ST.
  - Then 1 not-taken update → still predicts taken (WT).
  - A 2nd not-taken update → WNT, `pred_taken`=0.
  - 2 more not-taken updates → SNT, and it stays there.
- Alias eviction with INDEX_BITS=6:
  - 0x100 and 0x200 share index 0; 0x200 misses while 0x100 is allocated.
  - Not-taken update of 0x200 → 0x100 entry intact.
  - Taken update of 0x200 with target 0x180 → 0x100 then misses, and 0x200 predicts 0x180.
- Same-cycle lookup and update of 0x100 (taken, entry at WNT) → lookup that cycle shows `pred_taken`=0; the next cycle shows 1.
- Reset mid-stream:
  - Train 4 PCs, then assert `rst` together with `upd_valid` → all predictions 0 and `branch_count`=0 afterward.
  - After `rst` deasserts, one taken update → `branch_count`=1.
